piso_rr_serializer_ctrl: RTL and testbench
==========================================

Name: piso_rr_serializer_ctrl

Overview:
Controller that shares one serial output lane between NREQ parallel-word requesters. Round-robin arbitration picks one requester per frame and accepts its word through a valid/ready handshake. The word is loaded into an internal shift register and shifted out LSB-first, one bit per shift_en strobe, with frame markers. It sits between the parallel producers and the serial link / PISO output stage.

Parameters:
WIDTH, 4, bits per word (>=2)
NREQ, 4, number of requesters (>=2)
IDX_W, $clog2(NREQ), localparam; width of grant_id

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*WIDTH  packed words; requester i in bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot accept; combinational from state/valid/pointer
shift_en  input  1  bit-rate strobe; one bit shifted per asserted cycle in SHIFT
ser_out  output  1  serial data bit, registered
ser_valid  output  1  1-cycle pulse per bit emitted, registered
frame_start  output  1  high with ser_valid on bit 0 of a frame
frame_end  output  1  high with ser_valid on bit WIDTH-1 of a frame
grant_id  output  IDX_W  index of requester owning the current/last frame
busy  output  1  high while state != IDLE

Behaviour:
- Asynchronous reset (any time, including mid-frame): state=IDLE, shreg=0, cnt=0, rr_ptr=0; ser_out=0, ser_valid=0, frame_start=0, frame_end=0, grant_id=0, busy=0. Partial frame discarded; no frame_end issued.
- Two states: IDLE, SHIFT.
- IDLE: winner g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[g]=1 same cycle; all other bits 0. No valid -> req_ready=0, stay IDLE.
- Accept (req_valid[g] & req_ready[g]): next edge shreg<=req_data[g], cnt<=0, grant_id<=g, rr_ptr<=(g+1) mod NREQ (wraps NREQ-1 -> 0), state<=SHIFT.
- req_ready=0 in SHIFT. Requesters may deassert valid before acceptance; data sampled only at handshake edge.
- SHIFT, shift_en=1: ser_out<=shreg[0], shreg<=shreg>>1, ser_valid<=1, frame_start<=(cnt==0), frame_end<=(cnt==WIDTH-1), cnt<=cnt+1. If cnt==WIDTH-1 -> state<=IDLE.
- SHIFT, shift_en=0: ser_valid, frame_start, frame_end <=0; ser_out, shreg, cnt hold. No timeout.
- shift_en ignored in IDLE (ser_valid=0).
- Latency: accept at edge N -> first bit valid after first edge >N with shift_en=1. Back-to-back: IDLE costs exactly one cycle between frames; accept happens in that IDLE cycle.
- Fairness: a continuously valid requester waits at most NREQ-1 frames.
- cnt width $clog2(WIDTH+1); no overflow since it returns to IDLE at WIDTH-1.

Decomposition:
- Package piso_ctrl_pkg: state enum {IDLE, SHIFT}; clog2-based width helpers.
- Sub-module rr_arbiter_comb (NREQ): inputs req, ptr; outputs one-hot grant, grant index, any. Pure combinational; pointer register stays in the controller.

Test Plan:
- Reset mid-frame: WIDTH=4, accept 4'b1011, assert reset after 2 bits -> all outputs 0 immediately, busy=0; next accept starts at rr_ptr=0.
- Single requester: req 1 valid, data 4'b1011, shift_en always 1 -> req_ready=4'b0010 one cycle; ser_out 1,1,0,1 on four consecutive ser_valid pulses; frame_start on bit 0, frame_end on bit 3; grant_id=1.
- Round-robin wrap: all four valid continuously -> grant order 0,1,2,3,0; one IDLE cycle between frames; busy low only in those cycles.
- Sparse strobe: shift_en high every 3rd cycle -> ser_valid pulses only on those cycles; ser_out holds between; frame takes 12 cycles after accept.
- Pointer skip: rr_ptr=2, only req 0 valid -> grant 0, rr_ptr becomes 1; then req 0 and 3 valid -> grant 3.
- Withdrawn request: req 2 valid in SHIFT, dropped before frame end -> never granted, req_ready[2] never asserted.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// Shared types and width helpers for the round-robin PISO serializer controller.
package piso_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index width for n items; never returns zero so a single item still gets a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping modulo NREQ.
module rr_arbiter_comb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int unsigned      cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_any_s;

  // Scan farthest-from-pointer first so the nearest valid requester overwrites and wins.
  always_comb begin
    cand_s     = 32'd0;
    cand_idx_s = '0;
    win_idx_s  = '0;
    win_any_s  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s     = (32'(ptr) + 32'(k)) % 32'(NREQ);
      cand_idx_s = IDX_W'(cand_s);
      if (req[cand_idx_s]) begin
        win_idx_s = cand_idx_s;
        win_any_s = 1'b1;
      end else begin
        win_idx_s = win_idx_s;
        win_any_s = win_any_s;
      end
    end
  end

  // One-hot decode of the winning index.
  always_comb begin
    grant = '0;
    if (win_any_s) begin
      grant[win_idx_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  assign grant_idx = win_idx_s;
  assign any       = win_any_s;

endmodule

// File: rtl/piso_rr_serializer_ctrl.sv
// Shares one serial lane among NREQ word producers: round-robin accept, then LSB-first shift-out.
module piso_rr_serializer_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  shift_en,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  busy
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NREQ - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [IDX_W-1:0] grant_id_r, grant_id_s;
  logic             ser_out_r, ser_out_s;
  logic             ser_valid_r, ser_valid_s;
  logic             frame_start_r, frame_start_s;
  logic             frame_end_r, frame_end_s;
  logic [NREQ-1:0]  req_ready_s;

  logic [NREQ-1:0]  arb_grant_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             arb_any_s;
  logic [WIDTH-1:0] sel_word_s;

  rr_arbiter_comb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any       (arb_any_s)
  );

  // AND-OR mux of the granted requester's word; the grant is one-hot.
  always_comb begin
    sel_word_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_word_s = sel_word_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{arb_grant_s[i]}});
    end
  end

  // Next-state and registered-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_s       = state_r;
    shreg_s       = shreg_r;
    cnt_s         = cnt_r;
    rr_ptr_s      = rr_ptr_r;
    grant_id_s    = grant_id_r;
    ser_out_s     = ser_out_r;
    ser_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    req_ready_s   = '0;
    case (state_r)
      IDLE: begin
        req_ready_s = arb_grant_s;
        if (arb_any_s) begin
          shreg_s    = sel_word_s;
          cnt_s      = '0;
          grant_id_s = arb_idx_s;
          rr_ptr_s   = (arb_idx_s == LAST_REQ) ? '0 : arb_idx_s + IDX_W'(1);
          state_s    = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          ser_out_s     = shreg_r[0];
          shreg_s       = {1'b0, shreg_r[WIDTH-1:1]};
          ser_valid_s   = 1'b1;
          frame_start_s = (cnt_r == '0);
          frame_end_s   = (cnt_r == LAST_BIT);
          cnt_s         = cnt_r + CNT_W'(1);
          state_s       = (cnt_r == LAST_BIT) ? IDLE : SHIFT;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      shreg_r       <= '0;
      cnt_r         <= '0;
      rr_ptr_r      <= '0;
      grant_id_r    <= '0;
      ser_out_r     <= 1'b0;
      ser_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      shreg_r       <= shreg_s;
      cnt_r         <= cnt_s;
      rr_ptr_r      <= rr_ptr_s;
      grant_id_r    <= grant_id_s;
      ser_out_r     <= ser_out_s;
      ser_valid_r   <= ser_valid_s;
      frame_start_r <= frame_start_s;
      frame_end_r   <= frame_end_s;
    end
  end

  assign req_ready   = req_ready_s;
  assign ser_out     = ser_out_r;
  assign ser_valid   = ser_valid_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign grant_id    = grant_id_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_piso_rr_serializer_ctrl.sv
// Directed bench with a scoreboard: stimulus pushes expected serial bits, a monitor pops them.
module tb_piso_rr_serializer_ctrl;

  typedef struct packed {
    logic       b;
    logic       fs;
    logic       fe;
    logic [1:0] gid;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        shift_en;
  logic        ser_out;
  logic        ser_valid;
  logic        frame_start;
  logic        frame_end;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0] words [4];
  exp_t       sb_q [$];
  exp_t       mon_e;
  int         checks;
  int         failures;

  piso_rr_serializer_ctrl #(.WIDTH(4), .NREQ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .shift_en    (shift_en),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int gid, input logic [3:0] word);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.b   = word[b];
      e.fs  = (b == 0);
      e.fe  = (b == 3);
      e.gid = 2'(gid);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every emitted bit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && ser_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit actual=%0h expected=none", {ser_out, frame_start, frame_end, grant_id});
      end else begin
        mon_e = sb_q.pop_front();
        chk("ser_bit", 32'({ser_out, frame_start, frame_end, grant_id}), 32'(mon_e));
      end
    end
  end

  initial begin
    words[0] = 4'b0110;
    words[1] = 4'b1011;
    words[2] = 4'b1100;
    words[3] = 4'b1001;
    req_data  = {words[3], words[2], words[1], words[0]};
    req_valid = 4'b0000;
    shift_en  = 1'b1;
    reset     = 1'b1;
    checks    = 0;
    failures  = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({ser_out, ser_valid, frame_start, frame_end, grant_id, busy, req_ready}), 32'd0);
    reset = 1'b0;

    // Single requester 1 with a withdrawn request 2 during the frame
    @(negedge clk);
    req_valid = 4'b0010;
    #1 chk("t2_ready", 32'(req_ready), 32'h2);
    push_frame(1, words[1]);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_gid", 32'(grant_id), 32'd1);
    chk("wd_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("wd_ready1", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_ready_idle", 32'(req_ready), 32'd0);

    // Pointer skip: rr_ptr=2, only req 0 valid, then req 0 and 3
    req_valid = 4'b0001;
    #1 chk("skip_ready0", 32'(req_ready), 32'h1);
    push_frame(0, words[0]);
    @(negedge clk);
    req_valid = 4'b1001;
    #1 chk("skip_shift_ready", 32'(req_ready), 32'd0);
    repeat (4) @(negedge clk);
    #1 chk("skip_ready3", 32'(req_ready), 32'h8);
    push_frame(3, words[3]);
    @(negedge clk);
    req_valid = 4'b0000;
    chk("skip_gid3", 32'(grant_id), 32'd3);
    repeat (4) @(negedge clk);

    // Round-robin wrap with all four continuously valid
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (f % 4)));
      chk("rr_gap_busy", 32'(busy), 32'd0);
      push_frame(f % 4, words[f % 4]);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("rr_busy", 32'(busy), 32'd1);
        if (c == 0) chk("rr_gid", 32'(grant_id), 32'(f % 4));
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;

    // Sparse strobe: shift_en every 3rd cycle, rr_ptr=1 so req 2 wins
    shift_en  = 1'b0;
    req_valid = 4'b0100;
    #1 chk("sp_ready", 32'(req_ready), 32'h4);
    push_frame(2, words[2]);
    @(negedge clk);
    req_valid = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      shift_en = ((k % 3) == 0);
      @(negedge clk);
      chk("sp_valid", 32'(ser_valid), 32'((k % 3) == 0));
      chk("sp_busy", 32'(busy), 32'(k < 12));
    end
    shift_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_shift_ignored", 32'({ser_valid, busy}), 32'd0);
    end

    // Reset mid-frame: rr_ptr=3, req 1 wins, reset after two bits
    req_valid = 4'b0010;
    #1 chk("rst_ready", 32'(req_ready), 32'h2);
    mon_e.b = 1'b1; mon_e.fs = 1'b1; mon_e.fe = 1'b0; mon_e.gid = 2'd1;
    sb_q.push_back(mon_e);
    mon_e.b = 1'b1; mon_e.fs = 1'b0; mon_e.fe = 1'b0; mon_e.gid = 2'd1;
    sb_q.push_back(mon_e);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({ser_out, ser_valid, frame_start, frame_end, grant_id, busy}), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1010;
    #1 chk("rst_ptr_ready", 32'(req_ready), 32'h2);
    push_frame(1, words[1]);
    @(negedge clk);
    req_valid = 4'b0000;

    // Bounded drain of the scoreboard
    for (int t = 0; t < 40 && (sb_q.size() != 0 || busy); t++) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
